serial_adsub: RTL and testbench
===============================

# serial_adsub

Bit-serial two's-complement adder/subtractor with a valid/ready front end and back end. It accepts parallel operands, processes one bit per clock LSB-first through a single full-adder cell, and returns a parallel result. It is the area-minimal, multi-cycle counterpart of the parallel ripple add/sub datapath, for use where operands arrive over a handshake and throughput of one result per WIDTH+2 cycles is acceptable.

## Interface
Parameters:
- WIDTH, default 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0 = a+b, 1 = a−b, computed as a + ~b + 1.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB. For subtraction, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow, computed as carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b and sub; load the carry register with sub; clear the bit counter; go to RUN.
- RUN, one bit i per cycle (i = counter):
  - s_i = a_i ^ (b_i ^ sub) ^ carry.
  - carry ← majority(a_i, b_i ^ sub, carry).
  - Shift s_i into the result shift register at the MSB side, so that after WIDTH shifts s[0] is bit 0.
  - At i=WIDTH−2, capture the updated carry as the MSB carry-in.
  - At i=WIDTH−1, write cout = final carry and ovf = MSB carry-in ^ final carry; go to DONE.
- DONE:
  - out_valid=1. s, cout and ovf are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready, go to IDLE.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- sub is sampled only at acceptance. Changes on a, b or sub during RUN or DONE have no effect.
- Reset is asynchronous in any state, including mid-RUN or DONE:
  - State → IDLE.
  - s, cout, ovf, counter, carry and operand registers → 0.
  - out_valid=0; in_ready=1 once rst_n is high. A partially computed result is discarded.

## Timing
- Acceptance edge E0. Bits are processed on edges E1..E_WIDTH. out_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Result handshake completes on the first edge with out_valid && out_ready. in_ready is 1 in the following cycle.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH compute cycles, one DONE cycle with out_ready already high.
- While out_ready is low, the block stalls in DONE indefinitely with no data loss.

## Test plan
All scenarios use WIDTH=4.
- Addition with signed overflow: a=5, b=3, sub=0 → s=8, cout=0, ovf=1. out_valid is first seen 4 cycles after acceptance.
- Subtraction, no borrow: a=5, b=3, sub=1 → s=2, cout=1, ovf=0.
- Subtraction with borrow: a=3, b=5, sub=1 → s=14, cout=0, ovf=0.
- Wrap and negative overflow:
  - a=15, b=1, sub=0 → s=0, cout=1, ovf=0.
  - a=8, b=1, sub=1 → s=7, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid while toggling a, b, sub and in_valid. Required: s, cout, ovf stable; in_ready=0; no new acceptance. Release out_ready, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle of a=5, b=3, sub=1. Required: outputs immediately 0, out_valid=0. After release, a=6, b=6, sub=1 → s=0, cout=1, ovf=0. Also run 100 random back-to-back operations and compare against a+b / a−b mod 16.

Source files
------------

// File: rtl/serial_adsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first,
// parallel operands in and parallel result out over valid/ready handshakes.

module serial_adsub_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt;
  logic             sub_q, carry, cin_msb, cout_q, ovf_q;
  logic             fa_s, fa_co, last_bit;

  assign last_bit = (cnt == CW'(WIDTH-1));

  // Operands shift right each RUN cycle, so bit 0 is always the current bit.
  serial_adsub_fa u_fa (
    .x  (a_q[0]),
    .y  (b_q[0] ^ sub_q),
    .ci (carry),
    .sum(fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt     <= '0;
      sub_q   <= 1'b0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          sub_q <= sub;
          carry <= sub;   // +1 of the two's-complement negate
          cnt   <= '0;
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          s_q   <= {fa_s, s_q[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-2)) cin_msb <= fa_co;
          if (last_bit) begin
            cout_q <= fa_co;
            ovf_q  <= cin_msb ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adsub.sv
// Randomized and directed checks of serial_adsub against an integer-arithmetic model.

module tb_serial_adsub;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         sub = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout, ovf;

  int n_chk = 0, n_err = 0;

  serial_adsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic void model(input int av, input int bv, input bit sb,
                                output int es, output int ec, output int eo);
    int ua, ub, sa, sbv, r, u;
    ua  = av; ub = bv;
    sa  = (av >= 8) ? av - 16 : av;
    sbv = (bv >= 8) ? bv - 16 : bv;
    if (sb) begin
      u  = ua - ub;
      ec = (ua >= ub) ? 1 : 0;
      r  = sa - sbv;
    end else begin
      u  = ua + ub;
      ec = (u >= 16) ? 1 : 0;
      r  = sa + sbv;
    end
    es = ((u % 16) + 16) % 16;
    eo = (r > 7 || r < -8) ? 1 : 0;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Accept one op; returns at the negedge where out_valid is first seen.
  task automatic issue(input int av, input int bv, input bit sb, input string tag,
                       output int lat);
    wait_ready(tag);
    a = W'(av); b = W'(bv); sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!out_valid) chk({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic check_result(input int av, input int bv, input bit sb, input string tag);
    int es, ec, eo;
    model(av, bv, sb, es, ec, eo);
    chk({tag, "_s"}, int'(s), es);
    chk({tag, "_cout"}, int'(cout), ec);
    chk({tag, "_ovf"}, int'(ovf), eo);
  endtask

  task automatic run_op(input int av, input int bv, input bit sb, input string tag);
    int lat;
    issue(av, bv, sb, tag, lat);
    check_result(av, bv, sb, tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready_after"}, int'(in_ready), 1);
    chk({tag, "_out_valid_after"}, int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, hs, hc, ho;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_s", int'(s), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    issue(5, 3, 1'b0, "add_ovf", lat);
    chk("add_ovf_latency", lat, W);
    check_result(5, 3, 1'b0, "add_ovf");
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    run_op(5, 3, 1'b1, "sub_nb");
    run_op(3, 5, 1'b1, "sub_borrow");
    run_op(15, 1, 1'b0, "wrap");
    run_op(8, 1, 1'b1, "neg_ovf");

    // Back-pressure: result held while inputs churn.
    issue(9, 12, 1'b0, "bp", lat);
    check_result(9, 12, 1'b0, "bp");
    hs = int'(s); hc = int'(cout); ho = int'(ovf);
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      chk("bp_s_hold", int'(s), hs);
      chk("bp_cout_hold", int'(cout), hc);
      chk("bp_ovf_hold", int'(ovf), ho);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;

    // Reset during the second RUN cycle.
    wait_ready("rst_mid");
    a = 4'd5; b = 4'd3; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid_s", int'(s), 0);
    chk("rst_mid_cout", int'(cout), 0);
    chk("rst_mid_ovf", int'(ovf), 0);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    run_op(6, 6, 1'b1, "post_rst");

    // Back-to-back random ops with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int ra, rb;
      bit rs;
      ra = int'($urandom_range(0, 15)); rb = int'($urandom_range(0, 15)); rs = 1'($urandom);
      issue(ra, rb, rs, "rand", lat);
      chk("rand_latency", lat, W);
      check_result(ra, rb, rs, "rand");
      @(negedge clk);
      chk("rand_in_ready", int'(in_ready), 1);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
